// File: rtl/arb4way16_pkg.sv
// rtl/arb4way16_pkg.sv - shared constants and winner selection for arb4way16
package arb4way16_pkg;

  localparam int W    = 16;
  localparam int NREQ = 4;

  // Rotating-priority pick: look at requests starting one past the last
  // winner, take the first one set, then map back to an absolute index.
  function automatic logic [1:0] pick_winner(input logic [NREQ-1:0] req_v,
                                             input logic [1:0]      ptr);
    logic [1:0]        start;
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [1:0]        off;
    start = ptr + 2'd1;
    dbl   = {req_v, req_v};
    rot   = dbl[start +: NREQ];
    off   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = 2'(i);
    end
    return start + off;
  endfunction

endpackage

// File: rtl/arb4way16_mux4way16.sv
// rtl/arb4way16_mux4way16.sv - 4-way 16-bit word selector
module Mux4Way16
  import arb4way16_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic [1:0]   sel,
  output logic [W-1:0] out
);

  // Plain select; the arbiter decides which source is live.
  always_comb begin
    out = a;
    case (sel)
      2'd0: out = a;
      2'd1: out = b;
      2'd2: out = c;
      2'd3: out = d;
      default: out = a;
    endcase
  end

endmodule

// File: rtl/arb4way16.sv
// rtl/arb4way16.sv - round-robin 4-way arbiter with one-entry 16-bit output register
module arb4way16
  import arb4way16_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [W-1:0]    c,
  input  logic [W-1:0]    d,
  output logic [NREQ-1:0] ack,
  output logic [W-1:0]    out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      grant
);

  logic [W-1:0] out_q, out_d;
  logic         out_valid_q, out_valid_d;
  logic [1:0]   grant_q, grant_d;
  logic [1:0]   ptr_q, ptr_d;

  logic         load_ok;
  logic         load;
  logic [1:0]   winner;
  logic [W-1:0] mux_out;

  assign load_ok = !out_valid_q || out_ready;
  assign load    = load_ok && (req != '0);
  assign winner  = pick_winner(req, ptr_q);

  Mux4Way16 u_mux (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (winner),
    .out (mux_out)
  );

  // Next-state: load a new word when the slot is free, else drain or hold.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_d       = mux_out;
      out_valid_d = 1'b1;
      grant_d     = winner;
      ptr_d       = winner;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Ack is combinational; held low during reset so no requester sees a phantom capture.
  always_comb begin
    ack = '0;
    if (load && !reset) ack[winner] = 1'b1;
  end

  // Arbitration and output state; ptr starts at 3 so requester 0 goes first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      grant_q     <= 2'd0;
      ptr_q       <= 2'd3;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_arb4way16.sv
// tb/tb_arb4way16.sv - scoreboard bench for arb4way16
module tb_arb4way16;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] a, b, c, d;
  logic [3:0]  ack;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  grant;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [17:0] sb_q[$];

  logic [1:0] m_ptr;
  logic       m_valid;

  arb4way16 dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .ack       (ack),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, time=%0t required < 2000000", $time);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle: inputs settle after the edge, ack is checked mid-cycle,
  // and the expected captured word is queued for the monitor.
  task automatic step(input logic [3:0] r, input logic rdy, input logic [3:0] exp_ack,
                      input string nm);
    logic [1:0]  w;
    logic [15:0] word;
    req       = r;
    out_ready = rdy;
    @(negedge clk);
    chk(nm, {28'd0, ack}, {28'd0, exp_ack});
    n_cmp++;
    if ($countones(ack) > 1) begin
      n_fail++;
      $display("FAIL %s_onehot: got %b expected one-hot or zero", nm, ack);
    end
    if (exp_ack != 4'b0) begin
      w = 2'd0;
      for (int i = 0; i < 4; i++) if (exp_ack[i]) w = 2'(i);
      case (w)
        2'd0: word = a;
        2'd1: word = b;
        2'd2: word = c;
        default: word = d;
      endcase
      sb_q.push_back({w, word});
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every word taken by the consumer must match the next expected entry.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra: got grant=%0d out=%h expected no word", grant, out);
      end else begin
        logic [17:0] e;
        e = sb_q.pop_front();
        if ({grant, out} !== e) begin
          n_fail++;
          $display("FAIL sb_word: got grant=%0d out=%h expected grant=%0d out=%h",
                   grant, out, e[17:16], e[15:0]);
        end
      end
    end
  end

  function automatic logic [3:0] model_ack(input logic [3:0] r, input logic rdy);
    logic [1:0] idx;
    model_ack = 4'b0;
    if (m_valid && !rdy) return 4'b0;
    idx = m_ptr;
    for (int k = 0; k < 4; k++) begin
      idx = idx + 2'd1;
      if (r[idx]) begin
        model_ack[idx] = 1'b1;
        return model_ack;
      end
    end
  endfunction

  initial begin
    logic [3:0] r, e;
    logic       rdy;
    reset = 1'b1; req = 4'b1111; out_ready = 1'b1;
    a = 16'h1111; b = 16'h2222; c = 16'h3333; d = 16'h4444;

    // Reset with all requests high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", {16'd0, out}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_ack", {28'd0, ack}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Round robin 0,1,2,3,0.
    step(4'b1111, 1'b1, 4'b0001, "rr0");
    chk("lat_out", {16'd0, out}, 32'h1111);
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    step(4'b1111, 1'b1, 4'b0010, "rr1");
    step(4'b1111, 1'b1, 4'b0100, "rr2");
    step(4'b1111, 1'b1, 4'b1000, "rr3");
    step(4'b1111, 1'b1, 4'b0001, "rr4");

    // Single requester.
    c = 16'hBEEF;
    step(4'b0100, 1'b1, 4'b0100, "single");
    chk("single_out", {16'd0, out}, 32'hBEEF);
    chk("single_grant", {30'd0, grant}, 32'd2);
    chk("single_valid", {31'd0, out_valid}, 32'd1);

    // Stall: nothing moves while the consumer is not ready.
    a = 16'hAAAA; b = 16'hBBBB;
    for (int i = 0; i < 5; i++) begin
      step(4'b0011, 1'b0, 4'b0000, "stall_ack");
      chk("stall_out", {16'd0, out}, 32'hBEEF);
    end
    step(4'b0011, 1'b1, 4'b0001, "unstall");
    chk("unstall_out", {16'd0, out}, 32'hAAAA);

    // Drain without reload.
    step(4'b0000, 1'b1, 4'b0000, "drain");
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_out", {16'd0, out}, 32'hAAAA);
    chk("drain_grant", {30'd0, grant}, 32'd0);

    // Reset while holding a word.
    step(4'b0010, 1'b0, 4'b0010, "pre_rst");
    req = 4'b1111;
    #2 reset = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_ack", {28'd0, ack}, 32'd0);
    chk("midrst_out", {16'd0, out}, 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    req = 4'b0000;

    // Random phase against the model.
    m_ptr = 2'd3; m_valid = 1'b0;
    for (int it = 0; it < 1000; it++) begin
      r   = 4'($urandom_range(0, 15));
      rdy = 1'($urandom_range(0, 3) != 0);
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
      e = model_ack(r, rdy);
      step(r, rdy, e, "rnd_ack");
      if (e != 4'b0) begin
        m_valid = 1'b1;
        for (int i = 0; i < 4; i++) if (e[i]) m_ptr = 2'(i);
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end

    // Flush the last word and confirm nothing is left over.
    step(4'b0000, 1'b1, 4'b0000, "flush");
    chk("sb_empty", sb_q.size(), 32'd0);
    chk("end_valid", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/arb4way16.md
# arb4way16

Round-robin arbiter that shares one 16-bit output channel among four requesters. It drives a `Mux4Way16` select from a rotating-priority decision and captures the selected word into a one-entry output register. It also runs a valid/ack handshake toward each requester and a valid/ready handshake toward the consumer. The block sits between up to four word producers (e.g. register-file ports, IO sources) and a single downstream sink.

## Interface
Parameters:
- none; width fixed at 16, requester count fixed at 4.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req`  in  4  `req[i]`=1: requester i offers a word this cycle.
- `a`, `b`, `c`, `d`  in  16 each  data of requesters 0..3; must be stable while the matching `req` is high.
- `ack`  out  4  combinational one-hot. `ack[i]`=1: requester i's word is captured at this rising edge.
- `out`  out  16  registered output word.
- `out_valid`  out  1  `out` holds an unconsumed word.
- `out_ready`  in  1  consumer accepts `out` at this edge when `out_valid`=1.
- `grant`  out  2  index of the requester whose word is in `out`.

## Operation
- Slot-free condition: `load_ok = !out_valid || out_ready`.
- Load condition: `load = load_ok && (req != 0)`.
- Winner selection: search starts at index `(ptr+1) mod 4` and wraps. The first i with `req[i]`=1 wins, so the last winner has lowest priority.
- `ptr` resets to 3, which gives index 0 first priority after reset.
- Datapath: a `Mux4Way16` instance with `sel`=winner feeds the `out` register.
- On `load`:
  - `out` ← mux output
  - `grant` ← winner
  - `ptr` ← winner
  - `out_valid` ← 1
  - `ack[winner]`=1 in the same cycle; all other `ack` bits are 0.
- Consume without reload: when `out_valid && out_ready && req==0`, `out_valid` ← 0. `out` and `grant` hold their values.
- Back-to-back: when `out_valid && out_ready` and any `req` is high, the old word is consumed and the new word is loaded at the same edge. `out_valid` stays 1, giving a throughput of 1 word/cycle.
- Stall: when `out_valid && !out_ready`, `ack`=0 and all registers hold.
- Requester rule:
  - After seeing `ack[i]`, requester i either drops `req[i]` or presents its next word in the following cycle.
  - A requester holding `req` high is never starved. It wins within 4 loads.
- States (derived from `out_valid`):
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- Transitions:
  - EMPTY→FULL on `load`.
  - FULL→FULL on stall or back-to-back.
  - FULL→EMPTY on consume without reload.
- Reset mid-transfer: the held word is discarded and `ack` goes to 0 immediately. No partial state survives.

## Timing
- Reset values:
  - `out`=0
  - `out_valid`=0
  - `grant`=0
  - `ptr`=3
  - `ack`=0 (because `out_valid`=0 and `req` gates `ack`; `ack` is forced to 0 while `reset` is high)
- Latency: a word offered with `req[i]` high at edge k, and chosen, appears on `out` with `out_valid`=1 after edge k. The output is available in cycle k+1.
- `ack` depends combinationally on `req`, `out_valid`, `out_ready` and `ptr`. It has no register stage.
- The consumer sees each accepted word exactly once, in grant order.

## Structure
- No shared package is needed. If one already exists, the width (16) and requester count (4) may live in it as constants.
- One sub-module instance: `Mux4Way16` (existing part) as the data selector.
- Winner selection is a small rotate / priority-encode / rotate-back function internal to the block.
- Register the arbitration state (`ptr`, `grant`, `out_valid`) in a single always block with async reset.

## Test plan
- Reset:
  - Assert `reset` with `req`=4'b1111 held.
  - Required: `out`=0, `out_valid`=0, `grant`=0, `ack`=0.
  - Release `reset`. First edge: `ack`=4'b0001, then `out`=`a`, `grant`=0.
- Single requester:
  - `req`=4'b0100, `c`=16'hBEEF, `out_ready`=1.
  - Required: `ack`=4'b0100 in the same cycle; next cycle `out`=16'hBEEF, `out_valid`=1, `grant`=2.
- Round robin:
  - `req`=4'b1111 held, `out_ready`=1, `a..d`=16'h1111/2222/3333/4444.
  - Required: grants 0,1,2,3,0 on consecutive cycles; `out` follows 1111, 2222, 3333, 4444, 1111.
- Stall:
  - `out_valid`=1, `out_ready`=0, `req`=4'b0011 for 5 cycles.
  - Required: `ack`=0 and `out` unchanged throughout. Raise `out_ready`: the next grant goes to the index after the current `grant`.
- Drain:
  - `out_valid`=1, `out_ready`=1, `req`=0.
  - Required: next cycle `out_valid`=0, with `out` and `grant` unchanged.
- Random compare (1000 iterations):
  - Randomize `req`, `a..d` and `out_ready`.
  - Check `out` against a reference model, and check `ack` is one-hot or zero.
